// File: rtl/tuser_tuple_bridge.sv
// tuser_tuple_bridge: moves tuples between the AXIS TUSER sideband and the
// packet processor. Ingress takes one tuple from the first beat of each
// packet. Egress queues the processor's tuples and re-attaches them in order
// to outgoing packets, with a zero-latency bypass when the queue is empty.
module tuser_tuple_bridge #(
  parameter int C_TUSER_WIDTH = 128,
  parameter int C_TUPLE_WIDTH = 128,
  parameter int C_FIFO_DEPTH  = 4,
  parameter int C_TUSER_HOLD  = 1,
  parameter int C_CNT_WIDTH   = 16,
  localparam int AW           = $clog2(C_FIFO_DEPTH),
  localparam int LW           = AW + 1
) (
  input  logic                     tuser_aclk,
  input  logic                     tuser_arst,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  input  logic [C_TUSER_WIDTH-1:0] s_axis_tuser,
  output logic                     tin_valid,
  output logic [C_TUPLE_WIDTH-1:0] tin_data,
  input  logic                     tout_valid,
  input  logic [C_TUPLE_WIDTH-1:0] tout_data,
  input  logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  input  logic                     m_axis_tlast,
  output logic [C_TUSER_WIDTH-1:0] m_axis_tuser,
  input  logic                     clr_counters,
  output logic [LW-1:0]            fifo_level,
  output logic [C_CNT_WIDTH-1:0]   tuple_ovf_cnt,
  output logic [C_CNT_WIDTH-1:0]   tuple_miss_cnt
);

  typedef enum logic {IN_SOP, IN_BODY}   in_state_e;
  typedef enum logic {OUT_SOP, OUT_BODY} out_state_e;

  in_state_e  in_state_q,  in_state_d;
  out_state_e out_state_q, out_state_d;

  logic [C_TUPLE_WIDTH-1:0] mem_q [C_FIFO_DEPTH];
  logic [AW-1:0]            rd_ptr_q, wr_ptr_q;
  logic [LW-1:0]            level_q, level_d;
  logic [C_TUPLE_WIDTH-1:0] hold_q;
  logic [C_CNT_WIDTH-1:0]   ovf_q, ovf_d, miss_q, miss_d;

  logic in_beat, out_beat, out_sop_beat;
  logic fifo_empty, fifo_full;
  logic bypass, push_req, push, pop, ovf, miss;
  logic [C_TUPLE_WIDTH-1:0] sop_tuple, tuple_out;

  // Upper TUSER bits beyond the tuple are intentionally ignored on ingress.
  logic unused_tuser;
  assign unused_tuser = ^s_axis_tuser;

  assign in_beat      = s_axis_tvalid & s_axis_tready;
  assign out_beat     = m_axis_tvalid & m_axis_tready;
  assign out_sop_beat = out_beat & (out_state_q == OUT_SOP);

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LW'(C_FIFO_DEPTH));

  // Queued tuples win over the live processor output; nothing available -> zero.
  assign sop_tuple = !fifo_empty ? mem_q[rd_ptr_q] :
                     tout_valid  ? tout_data       : '0;

  assign bypass   = out_sop_beat & fifo_empty & tout_valid;
  assign push_req = tout_valid & ~(out_sop_beat & fifo_empty);
  assign pop      = out_sop_beat & ~fifo_empty;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign push     = push_req & (~fifo_full | pop);
  assign ovf      = push_req & fifo_full & ~pop;
  assign miss     = out_sop_beat & fifo_empty & ~tout_valid;

  assign tin_valid = in_beat & (in_state_q == IN_SOP);
  assign tin_data  = s_axis_tuser[C_TUPLE_WIDTH-1:0];

  assign tuple_out    = (out_state_q == OUT_SOP) ? sop_tuple :
                        (C_TUSER_HOLD != 0)      ? hold_q    : '0;
  assign m_axis_tuser = C_TUSER_WIDTH'(tuple_out);

  assign fifo_level     = level_q;
  assign tuple_ovf_cnt  = ovf_q;
  assign tuple_miss_cnt = miss_q;

  // Packet-boundary tracking for both directions.
  always_comb begin
    in_state_d  = in_state_q;
    out_state_d = out_state_q;
    if (in_beat)  in_state_d  = s_axis_tlast  ? IN_SOP  : IN_BODY;
    if (out_beat) out_state_d = m_axis_tlast  ? OUT_SOP : OUT_BODY;
  end

  // Occupancy and saturating error counters; clear beats a same-cycle increment.
  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
    ovf_d  = ovf_q;
    miss_d = miss_q;
    if (clr_counters) begin
      ovf_d  = '0;
      miss_d = '0;
    end else begin
      if (ovf  && ovf_q  != '1) ovf_d  = ovf_q  + C_CNT_WIDTH'(1);
      if (miss && miss_q != '1) miss_d = miss_q + C_CNT_WIDTH'(1);
    end
  end

  // Control state, pointers, held tuple and counters.
  always_ff @(posedge tuser_aclk or posedge tuser_arst) begin
    if (tuser_arst) begin
      in_state_q  <= IN_SOP;
      out_state_q <= OUT_SOP;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      hold_q      <= '0;
      ovf_q       <= '0;
      miss_q      <= '0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
      miss_q      <= miss_d;
      if (push)         wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)          rd_ptr_q <= rd_ptr_q + AW'(1);
      if (out_sop_beat) hold_q   <= sop_tuple;
    end
  end

  // Tuple storage; contents are only read while the level says they are valid.
  always_ff @(posedge tuser_aclk) begin
    if (push) mem_q[wr_ptr_q] <= tout_data;
  end

  logic unused_bypass;
  assign unused_bypass = bypass;

endmodule

// File: tb/tb_tuser_tuple_bridge.sv
// Bench for tuser_tuple_bridge: two instances (hold mode with 16-bit counters,
// first-beat-only mode with 2-bit counters) share stimulus and are compared
// every cycle against a packet/queue level reference model.
module tb_tuser_tuple_bridge;
  localparam int TW = 64;
  localparam int UW = 128;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          s_tvalid, s_tready, s_tlast;
  logic [UW-1:0] s_tuser;
  logic          tout_valid;
  logic [TW-1:0] tout_data;
  logic          m_tvalid, m_tready, m_tlast;
  logic          clr;

  logic          tin_valid1, tin_valid0;
  logic [TW-1:0] tin_data1, tin_data0;
  logic [UW-1:0] m_tuser1, m_tuser0;
  logic [2:0]    level1, level0;
  logic [15:0]   ovf_cnt1, miss_cnt1;
  logic [1:0]    ovf_cnt0, miss_cnt0;

  tuser_tuple_bridge #(.C_TUSER_WIDTH(UW), .C_TUPLE_WIDTH(TW), .C_FIFO_DEPTH(D),
                       .C_TUSER_HOLD(1), .C_CNT_WIDTH(16)) u_hold (
    .tuser_aclk(clk), .tuser_arst(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser), .tin_valid(tin_valid1), .tin_data(tin_data1),
    .tout_valid(tout_valid), .tout_data(tout_data),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser1), .clr_counters(clr), .fifo_level(level1),
    .tuple_ovf_cnt(ovf_cnt1), .tuple_miss_cnt(miss_cnt1));

  tuser_tuple_bridge #(.C_TUSER_WIDTH(UW), .C_TUPLE_WIDTH(TW), .C_FIFO_DEPTH(D),
                       .C_TUSER_HOLD(0), .C_CNT_WIDTH(2)) u_nohold (
    .tuser_aclk(clk), .tuser_arst(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser), .tin_valid(tin_valid0), .tin_data(tin_data0),
    .tout_valid(tout_valid), .tout_data(tout_data),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser0), .clr_counters(clr), .fifo_level(level0),
    .tuple_ovf_cnt(ovf_cnt0), .tuple_miss_cnt(miss_cnt0));

  int checks = 0;
  int errors = 0;

  // Reference model: packet position flags, tuple queue, last attached tuple.
  bit            m_in_sop, m_out_sop;
  logic [TW-1:0] q[$];
  logic [TW-1:0] m_hold;
  int            ovf16, miss16, ovf2, miss2;

  task automatic chk(string tag, logic [UW-1:0] obs, logic [UW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_in_sop = 1; m_out_sop = 1;
    q.delete();
    m_hold = '0;
    ovf16 = 0; miss16 = 0; ovf2 = 0; miss2 = 0;
  endtask

  function automatic logic [TW-1:0] model_sop();
    if (q.size() > 0) return q[0];
    if (tout_valid)   return tout_data;
    return '0;
  endfunction

  // Check all outputs mid-cycle, then advance the model across the clock edge.
  task automatic step();
    logic [TW-1:0] sop;
    bit ib, ob, bypass_used;
    #2;
    if (rst) model_reset();
    ib  = s_tvalid & s_tready;
    ob  = m_tvalid & m_tready;
    sop = model_sop();
    chk("tin_valid_h",  {127'b0, tin_valid1}, {127'b0, ib & m_in_sop});
    chk("tin_valid_nh", {127'b0, tin_valid0}, {127'b0, ib & m_in_sop});
    chk("tin_data",     {64'b0, tin_data1},   {64'b0, s_tuser[TW-1:0]});
    chk("tin_data_nh",  {64'b0, tin_data0},   {64'b0, s_tuser[TW-1:0]});
    chk("tuser_h",  m_tuser1, {64'b0, (m_out_sop ? sop : m_hold)});
    chk("tuser_nh", m_tuser0, {64'b0, (m_out_sop ? sop : 64'b0)});
    chk("level_h",  {125'b0, level1}, UW'(q.size()));
    chk("level_nh", {125'b0, level0}, UW'(q.size()));
    chk("ovf16",  {112'b0, ovf_cnt1},  UW'(ovf16));
    chk("miss16", {112'b0, miss_cnt1}, UW'(miss16));
    chk("ovf2",   {126'b0, ovf_cnt0},  UW'(ovf2));
    chk("miss2",  {126'b0, miss_cnt0}, UW'(miss2));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      bypass_used = 0;
      if (ob && m_out_sop) begin
        m_hold = sop;
        if (q.size() > 0) void'(q.pop_front());
        else if (tout_valid) bypass_used = 1;
        else begin
          if (miss16 < 65535) miss16++;
          if (miss2 < 3) miss2++;
        end
      end
      if (tout_valid && !bypass_used) begin
        if (q.size() < D) q.push_back(tout_data);
        else begin
          if (ovf16 < 65535) ovf16++;
          if (ovf2 < 3) ovf2++;
        end
      end
      if (clr) begin
        ovf16 = 0; miss16 = 0; ovf2 = 0; miss2 = 0;
      end
      if (ob) m_out_sop = m_tlast;
      if (ib) m_in_sop  = s_tlast;
    end
    #1;
  endtask

  task automatic idle();
    s_tvalid = 0; s_tready = 1; s_tlast = 0;
    tout_valid = 0; m_tvalid = 0; m_tready = 1; m_tlast = 0; clr = 0;
  endtask

  task automatic out_pkt(int beats);
    m_tvalid = 1; m_tready = 1;
    for (int b = 0; b < beats; b++) begin
      m_tlast = (b == beats - 1);
      step();
    end
    m_tvalid = 0; m_tlast = 0;
  endtask

  initial begin
    idle();
    s_tuser = '0; tout_data = '0;
    model_reset();
    // Reset held for a few cycles.
    repeat (3) step();
    rst = 0;
    step();

    // Ingress: 3-beat packet stalled on beat 0, then a single-beat packet.
    s_tuser = {64'h1111_2222_3333_4444, 64'hDEAD_0000_0000_A5A5};
    s_tvalid = 1; s_tready = 0;
    step(); step();
    s_tready = 1; step();
    step();
    s_tlast = 1; step();
    s_tuser = {64'h0, 64'h0000_0000_0000_BEEF};
    step();
    idle(); step();

    // Egress ordering with 2-, 1- and 4-beat packets.
    tout_valid = 1;
    tout_data = 64'h1; step();
    tout_data = 64'h2; step();
    tout_data = 64'h3; step();
    tout_valid = 0;
    chk("plan_level3", {125'b0, level1}, 128'd3);
    out_pkt(2); chk("plan_level2", {125'b0, level1}, 128'd2);
    out_pkt(1); chk("plan_level1", {125'b0, level1}, 128'd1);
    out_pkt(4); chk("plan_level0", {125'b0, level1}, 128'd0);

    // Overflow: five pushes into a four-entry queue, then push+pop at full.
    tout_valid = 1;
    for (int i = 0; i < 5; i++) begin
      tout_data = 64'h100 + 64'(i);
      step();
    end
    chk("plan_ovf1",   {112'b0, ovf_cnt1}, 128'd1);
    chk("plan_level4", {125'b0, level1},   128'd4);
    tout_data = 64'h200;
    m_tvalid = 1; m_tlast = 1; step();
    chk("plan_ovf_keep", {112'b0, ovf_cnt1}, 128'd1);
    tout_valid = 0;
    // Head held stable while the sink stalls.
    m_tready = 0; step(); step();
    m_tready = 1;
    m_tvalid = 0; m_tlast = 0;
    repeat (4) out_pkt(1);

    // Bypass then miss.
    tout_valid = 1; tout_data = 64'h77;
    out_pkt(1);
    chk("plan_bypass_level", {125'b0, level1}, 128'd0);
    tout_valid = 0;
    out_pkt(1);
    chk("plan_miss1", {112'b0, miss_cnt1}, 128'd1);
    // Saturation of the 2-bit counter, then clear coinciding with a miss.
    repeat (4) out_pkt(1);
    chk("plan_sat", {126'b0, miss_cnt0}, 128'd3);
    clr = 1; out_pkt(1); clr = 0;
    chk("plan_clr", {112'b0, miss_cnt1}, 128'd0);

    // No-hold mode: 3-beat packet with a queued tuple.
    tout_valid = 1; tout_data = 64'hCAFE; step(); tout_valid = 0;
    out_pkt(3);

    // Reset mid-packet on both sides with a queued tuple.
    tout_valid = 1; tout_data = 64'h55; step(); tout_valid = 0;
    s_tvalid = 1; m_tvalid = 1; step();
    idle();
    rst = 1; #1;
    chk("rst_level", {125'b0, level1}, 128'd0);
    chk("rst_tuser", m_tuser1, 128'd0);
    step(); step();
    rst = 0;
    s_tvalid = 1; s_tlast = 0; s_tuser = 128'h9;
    step();
    idle(); step();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      s_tvalid   = ($urandom_range(0, 3) != 0);
      s_tready   = ($urandom_range(0, 3) != 0);
      s_tlast    = ($urandom_range(0, 2) == 0);
      s_tuser    = {$urandom, $urandom, $urandom, $urandom};
      tout_valid = ($urandom_range(0, 2) == 0);
      tout_data  = {$urandom, $urandom};
      m_tvalid   = ($urandom_range(0, 2) != 0);
      m_tready   = ($urandom_range(0, 3) != 0);
      m_tlast    = ($urandom_range(0, 2) == 0);
      clr        = ($urandom_range(0, 31) == 0);
      rst        = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 0; idle(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
